// File: rtl/apb_master_nslv.sv
// -----------------------------------------------------------------------------
// apb_master_nslv
//   APB3 master for a fixed set of peripheral slots. It takes one request at a
//   time from the bridge side, decodes the target slot from an address field,
//   runs a SETUP/ACCESS transfer on a one-hot PSEL vector, and returns the
//   result on a response channel that is held until consumed. Slave errors,
//   decode misses and ACCESS-phase timeouts are all reported as rsp_err.
//
// Ports
//   clk, rst                 clock (posedge) and synchronous active-high reset
//   req_valid/req_ready      request handshake (req_ready only while idle)
//   req_write/addr/wdata/strb request payload, captured on the handshake
//   rsp_valid/rsp_ready      response handshake, payload held while stalled
//   rsp_rdata/rsp_err        read data (0 for writes and errors), error flag
//   psel/penable/pwrite      APB control, psel one-hot over NSLV slots
//   paddr/pwdata/pstrb       APB address, write data, strobes (0 on reads)
//   prdata/pready/pslverr    per-slot return buses, slot i at [i*DW +: DW]
// -----------------------------------------------------------------------------
module apb_master_nslv #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int NSLV     = 6,
  parameter int SEL_LSB  = 8,
  parameter int SEL_W    = 3,
  parameter int BASE_IDX = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_addr,
  input  logic [DW-1:0]      req_wdata,
  input  logic [DW/8-1:0]    req_strb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [NSLV-1:0]    psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  output logic [DW/8-1:0]    pstrb,
  input  logic [NSLV*DW-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr
);

  localparam int SW    = DW / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  // Wait counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  function automatic logic [NSLV-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NSLV-1:0] r;
    r = '0;
    for (int i = 0; i < NSLV; i++) begin
      r[i] = (int'(idx) == i);
    end
    return r;
  endfunction

  state_t            r_state, w_state_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic [NSLV-1:0]   r_psel, w_psel_nxt;
  logic              r_penable, w_penable_nxt;
  logic              r_pwrite, w_pwrite_nxt;
  logic [AW-1:0]     r_paddr, w_paddr_nxt;
  logic [DW-1:0]     r_pwdata, w_pwdata_nxt;
  logic [SW-1:0]     r_pstrb, w_pstrb_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic [SEL_W-1:0]  w_field;
  logic [SEL_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_sel_pready;
  logic              w_sel_pslverr;
  logic [DW-1:0]     w_sel_prdata;

  // Slot index wraps modulo 2^SEL_W, so fields below BASE_IDX land above
  // NSLV-1 and fall into the decode-error path together with high fields.
  assign w_field    = req_addr[SEL_LSB +: SEL_W];
  assign w_idx      = w_field - SEL_W'(BASE_IDX);
  assign w_in_range = (int'(w_idx) < NSLV);

  // The registered one-hot psel doubles as the return-path mux select, so
  // unselected slots can never influence completion.
  assign w_sel_pready  = |(pready & r_psel);
  assign w_sel_pslverr = |(pslverr & r_psel);

  always_comb begin
    w_sel_prdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_psel[i]) w_sel_prdata = w_sel_prdata | prdata[i*DW +: DW];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_pstrb_nxt     = r_pstrb;
    w_cnt_nxt       = r_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_req_ready_nxt = 1'b0;
          w_paddr_nxt     = req_addr;
          w_pwrite_nxt    = req_write;
          w_pwdata_nxt    = req_wdata;
          w_pstrb_nxt     = req_write ? req_strb : '0;
          if (w_in_range) begin
            w_psel_nxt  = onehot(w_idx);
            w_state_nxt = S_SETUP;
          end else begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
            w_state_nxt     = S_RESP;
          end
        end
      end

      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_ACCESS;
      end

      S_ACCESS: begin
        if (w_sel_pready) begin
          w_psel_nxt      = '0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = w_sel_pslverr;
          w_rsp_rdata_nxt = (r_pwrite || w_sel_pslverr) ? '0 : w_sel_prdata;
          w_state_nxt     = S_RESP;
        end else if ((TIMEOUT > 0) && (r_cnt == TO_LAST)) begin
          w_psel_nxt      = '0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_state_nxt     = S_RESP;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pstrb     <= w_pstrb_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;

endmodule

// File: tb/tb_apb_master_nslv.sv
// -----------------------------------------------------------------------------
// tb_apb_master_nslv
//   Directed bench for apb_master_nslv with TIMEOUT=4. Inputs change 1 time
//   unit after the rising edge; outputs are observed at the same point, before
//   the new inputs are applied.
// -----------------------------------------------------------------------------
module tb_apb_master_nslv;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int NSLV = 6;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [AW-1:0]      req_addr;
  logic [DW-1:0]      req_wdata;
  logic [DW/8-1:0]    req_strb;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [NSLV-1:0]    psel;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW/8-1:0]    pstrb;
  logic [NSLV*DW-1:0] prdata;
  logic [NSLV-1:0]    pready;
  logic [NSLV-1:0]    pslverr;

  int checks;
  int failures;

  apb_master_nslv #(
    .AW(12), .DW(32), .NSLV(6), .SEL_LSB(8), .SEL_W(3), .BASE_IDX(2), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 1'b1; prdata = '0; pready = '0; pslverr = '0;
    tick(); tick(); tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (psel !== 6'b0) begin failures++; $display("FAIL reset_psel got=%b exp=000000", psel); end
    checks++; if (penable !== 1'b0 || pwrite !== 1'b0) begin failures++; $display("FAIL reset_pen_pwr got=%b%b exp=00", penable, pwrite); end
    checks++; if (paddr !== 12'h0 || pwdata !== 32'h0 || pstrb !== 4'h0) begin failures++; $display("FAIL reset_pbus got=%h/%h/%h exp=0/0/0", paddr, pwdata, pstrb); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    rst = 1'b0;
    tick();
  endtask

  // Zero-wait write to slot 0.
  task automatic test_write_zero_wait();
    pready = 6'b000001; pslverr = '0; rsp_ready = 1'b1;
    set_req(1'b1, 12'h200, 32'hA5A5_0001, 4'hF);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL t1_req_ready got=%b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 6'b000001 || penable !== 1'b0) begin failures++; $display("FAIL t1_setup got=psel %b pen %b exp=psel 000001 pen 0", psel, penable); end
    checks++; if (paddr !== 12'h200 || pwrite !== 1'b1 || pwdata !== 32'hA5A5_0001 || pstrb !== 4'hF) begin failures++; $display("FAIL t1_setup_bus got=%h %b %h %h exp=200 1 a5a50001 f", paddr, pwrite, pwdata, pstrb); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL t1_req_ready_busy got=%b exp=0", req_ready); end
    tick();
    checks++; if (psel !== 6'b000001 || penable !== 1'b1) begin failures++; $display("FAIL t1_access got=psel %b pen %b exp=psel 000001 pen 1", psel, penable); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_early_rsp got=%b exp=0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL t1_resp got=v%b e%b d%h exp=v1 e0 d0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (psel !== 6'b0 || penable !== 1'b0) begin failures++; $display("FAIL t1_resp_idle_bus got=psel %b pen %b exp=0 0", psel, penable); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL t1_back_idle got=v%b r%b exp=v0 r1", rsp_valid, req_ready); end
  endtask

  // Read from slot 5 with three wait states; other slots shout ready/error.
  task automatic test_read_wait();
    prdata = '0;
    prdata[5*DW +: DW] = 32'hDEAD_BEEF;
    prdata[4*DW +: DW] = 32'h4444_4444;
    pready = 6'b0; pslverr = '0; rsp_ready = 1'b1;
    set_req(1'b0, 12'h714, 32'h1234_5678, 4'hF);
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 6'b100000 || penable !== 1'b0) begin failures++; $display("FAIL t2_setup got=psel %b pen %b exp=100000 0", psel, penable); end
    checks++; if (pstrb !== 4'h0 || pwrite !== 1'b0 || paddr !== 12'h714) begin failures++; $display("FAIL t2_setup_bus got=strb %h wr %b addr %h exp=0 0 714", pstrb, pwrite, paddr); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (penable !== 1'b1 || psel !== 6'b100000 || rsp_valid !== 1'b0) begin failures++; $display("FAIL t2_access%0d got=pen %b psel %b v %b exp=1 100000 0", k, penable, psel, rsp_valid); end
      pready  = (k == 3) ? 6'b111111 : 6'b011111;
      pslverr = 6'b011111;
    end
    tick();
    pready = '0; pslverr = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t2_resp got=v%b e%b d%h exp=v1 e0 ddeadbeef", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (penable !== 1'b0 || psel !== 6'b0) begin failures++; $display("FAIL t2_resp_bus got=pen %b psel %b exp=0 0", penable, psel); end
    tick();
  endtask

  // Addresses whose slot field falls outside the slot range.
  task automatic test_decode_err();
    logic [AW-1:0] addrs [2];
    addrs[0] = 12'h0F0;
    addrs[1] = 12'h100;
    pready = 6'b111111; rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_req(1'b0, addrs[k], 32'h0, 4'h0);
      tick();
      req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL t3_resp%0d got=v%b e%b d%h exp=v1 e1 d0", k, rsp_valid, rsp_err, rsp_rdata); end
      checks++; if (psel !== 6'b0 || penable !== 1'b0) begin failures++; $display("FAIL t3_psel%0d got=psel %b pen %b exp=0 0", k, psel, penable); end
      tick();
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || psel !== 6'b0) begin failures++; $display("FAIL t3_idle%0d got=v%b r%b psel %b exp=v0 r1 0", k, rsp_valid, req_ready, psel); end
    end
    pready = '0;
  endtask

  // Slot 1 never answers: four ACCESS cycles then a forced error.
  task automatic test_timeout();
    pready = '0; pslverr = '0; rsp_ready = 1'b1;
    set_req(1'b1, 12'h300, 32'hCAFE_0003, 4'h3);
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 6'b000010) begin failures++; $display("FAIL t4_setup got=psel %b exp=000010", psel); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL t4_access%0d got=pen %b v %b exp=1 0", k, penable, rsp_valid); end
    end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL t4_resp got=v%b e%b d%h exp=v1 e1 d0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (penable !== 1'b0 || psel !== 6'b0) begin failures++; $display("FAIL t4_bus_off got=pen %b psel %b exp=0 0", penable, psel); end
    tick();
    pready = 6'b111111;
    set_req(1'b1, 12'h500, 32'h0000_0505, 4'h1);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL t4_next_ready got=%b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 6'b001000 || pstrb !== 4'h1) begin failures++; $display("FAIL t4_next_setup got=psel %b strb %h exp=001000 1", psel, pstrb); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin failures++; $display("FAIL t4_next_resp got=v%b e%b exp=v1 e0", rsp_valid, rsp_err); end
    tick();
    pready = '0;
  endtask

  // Slave error from slot 2, response stalled, pending request kept waiting.
  task automatic test_slverr_hold();
    prdata = '0;
    pready = 6'b000100; pslverr = 6'b000100; rsp_ready = 1'b0;
    set_req(1'b0, 12'h400, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 6'b000100) begin failures++; $display("FAIL t5_setup got=psel %b exp=000100", psel); end
    tick();
    tick();
    pready = '0; pslverr = '0;
    set_req(1'b1, 12'h200, 32'h0000_0099, 4'hF);
    for (int k = 0; k < 5; k++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || req_ready !== 1'b0) begin failures++; $display("FAIL t5_hold%0d got=v%b e%b d%h r%b exp=v1 e1 d0 r0", k, rsp_valid, rsp_err, rsp_rdata, req_ready); end
      checks++; if (psel !== 6'b0) begin failures++; $display("FAIL t5_hold_psel%0d got=%b exp=0", k, psel); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || psel !== 6'b0) begin failures++; $display("FAIL t5_release got=v%b r%b psel %b exp=v0 r1 0", rsp_valid, req_ready, psel); end
    pready = 6'b111111;
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 6'b000001 || pwdata !== 32'h0000_0099) begin failures++; $display("FAIL t5_next_setup got=psel %b wd %h exp=000001 99", psel, pwdata); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin failures++; $display("FAIL t5_next_resp got=v%b e%b exp=v1 e0", rsp_valid, rsp_err); end
    tick();
    pready = '0;
  endtask

  // Reset while slot 4 is in ACCESS, then a clean read from the same slot.
  task automatic test_reset_mid();
    prdata = '0;
    prdata[4*DW +: DW] = 32'h4444_0004;
    pready = '0; pslverr = '0; rsp_ready = 1'b1;
    set_req(1'b0, 12'h600, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (penable !== 1'b1 || psel !== 6'b010000) begin failures++; $display("FAIL t6_access got=pen %b psel %b exp=1 010000", penable, psel); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (psel !== 6'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL t6_abort got=psel %b pen %b v %b r %b exp=0 0 0 1", psel, penable, rsp_valid, req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || psel !== 6'b0) begin failures++; $display("FAIL t6_no_rsp got=v%b psel %b exp=0 0", rsp_valid, psel); end
    pready = 6'b010000;
    set_req(1'b0, 12'h600, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 6'b010000 || pstrb !== 4'h0) begin failures++; $display("FAIL t6_setup got=psel %b strb %h exp=010000 0", psel, pstrb); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h4444_0004) begin failures++; $display("FAIL t6_resp got=v%b e%b d%h exp=v1 e0 d44440004", rsp_valid, rsp_err, rsp_rdata); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL t6_idle got=v%b r%b exp=v0 r1", rsp_valid, req_ready); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_decode_err();
    test_timeout();
    test_slverr_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
